state_dump: RTL
===============

// Module: state_dump
// PURPOSE
//   Hardware counterpart to bench-side state inspection: on request, halts the cpu, reads every
//   register (x0..xN-1) and every data-memory word through dedicated debug read ports, and
//   streams them out over a valid/ready interface. Sits beside cpu, wired to its debug ports.
// PARAMETERS
//   XLEN        32   data word width
//   NREGS       32   registers dumped, index 0..NREGS-1
//   DMEM_WORDS  64   data-memory words dumped, word address 0..DMEM_WORDS-1
// PORTS
//   clock         in   1                  rising-edge clock
//   reset         in   1                  asynchronous, active-high
//   start         in   1                  request dump; sampled only in IDLE
//   cpu_halt      out  1                  freezes cpu (PC/regfile/dmem writes) while high
//   reg_addr      out  $clog2(NREGS)      register read index
//   reg_rdata     in   XLEN               combinational read of reg_addr
//   mem_addr      out  $clog2(DMEM_WORDS) data-memory word address
//   mem_rdata     in   XLEN               combinational read of mem_addr
//   out_valid     out  1                  out_* holds a word
//   out_ready     in   1                  sink accepts word when out_valid&&out_ready
//   out_data      out  XLEN               dumped value
//   out_addr      out  16                 reg index or mem word address, zero-extended
//   out_is_mem    out  1                  0 = register word, 1 = memory word
//   out_last      out  1                  final word of dump
//   busy          out  1                  high in every state except IDLE
//   done          out  1                  one-cycle pulse at dump completion
// BEHAVIOUR
//   Reset (async): state IDLE; all outputs 0; internal index 0; output buffer empty.
//   FSM: IDLE -> HALT -> REGS -> MEM -> DONE -> IDLE.
//   - IDLE: start=1 at edge T -> HALT; cpu_halt=1 and busy=1 from T+1.
//   - HALT: exactly one cycle (lets in-flight cpu write retire); index<=0 -> REGS.
//   - REGS: reg_addr=index. One-entry output buffer: loads {reg_rdata,index,is_mem=0}
//     when buffer empty or being accepted this cycle; index++. After loading NREGS-1 -> MEM,
//     index<=0. First out_valid at T+2 carrying x0.
//   - MEM: same as REGS using mem_addr/mem_rdata, out_is_mem=1; load of word DMEM_WORDS-1
//     sets out_last=1; then wait for its handshake -> DONE.
//   - DONE: one cycle; done=1, cpu_halt=0, busy=0 next cycle -> IDLE.
//   Throughput: one word/cycle with out_ready held high; total NREGS+DMEM_WORDS handshakes.
//   Backpressure: while out_valid&&!out_ready, out_data/out_addr/out_is_mem/out_last stay
//     stable, index does not advance, no word skipped or duplicated.
//   out_valid never drops without handshake; out_last only on final word.
//   x0 dumped as read (expected 0); no special-casing.
//   start while busy: ignored. start held high: new dump begins after return to IDLE.
//   Reset mid-dump: immediate abort, cpu_halt drops asynchronously, no done pulse.
//   reg_addr/mem_addr = 0 outside REGS/MEM respectively.
// TESTING
//   1 Program leaves x1=5,x4=7,dmem[1]=12; start pulse, out_ready=1 -> 96 words in 96
//     consecutive cycles from T+2; word 1 = {5,addr 1,is_mem 0}; word 33 = {12,addr 1,is_mem 1};
//     out_last only on word 95; done pulse after it.
//   2 out_ready toggled 1/0 every cycle -> same 96-word sequence, no gaps/duplicates, data
//     stable while stalled; completes in ~192 cycles.
//   3 cpu_halt high from T+1 to DONE; cpu PC and x1..x31 unchanged across dump window.
//   4 start pulsed again mid-dump -> ignored, exactly one done pulse, 96 words.
//   5 reset asserted at word 40 -> all outputs 0 asynchronously; new start -> full 96-word
//     dump from x0.
//   6 out_ready=0 at first word for 10 cycles -> out_valid=1, out_data=x0 held, index frozen.

Source files
------------

// File: rtl/state_dump.sv
// Debug dump engine. It halts the cpu, then streams every register and every
// data-memory word out over a valid/ready port through a one-entry output buffer.
module state_dump #(
   parameter int XLEN       = 32,
   parameter int NREGS      = 32,
   parameter int DMEM_WORDS = 64
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   output logic                          cpu_halt,
   output logic [$clog2(NREGS)-1:0]      reg_addr,
   input  logic [XLEN-1:0]               reg_rdata,
   output logic [$clog2(DMEM_WORDS)-1:0] mem_addr,
   input  logic [XLEN-1:0]               mem_rdata,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [XLEN-1:0]               out_data,
   output logic [15:0]                   out_addr,
   output logic                          out_is_mem,
   output logic                          out_last,
   output logic                          busy,
   output logic                          done
);

   localparam int RAW = $clog2(NREGS);
   localparam int MAW = $clog2(DMEM_WORDS);
   localparam int IW  = (RAW > MAW) ? RAW : MAW;

   localparam logic [IW-1:0] LAST_REG = IW'(NREGS - 1);
   localparam logic [IW-1:0] LAST_MEM = IW'(DMEM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_REGS,
      S_MEM,
      S_DONE
   } state_t;

   state_t          state, state_d;
   logic [IW-1:0]   index, index_d;

   logic            valid_d;
   logic [XLEN-1:0] data_d;
   logic [15:0]     addr_d;
   logic            is_mem_d;
   logic            last_d;

   logic            accept;
   logic            can_load;

   // The buffer may refill in the same cycle its current word is taken,
   // which is what sustains one word per cycle under continuous ready.
   assign accept   = out_valid && out_ready;
   assign can_load = !out_valid || out_ready;

   assign cpu_halt = (state != S_IDLE);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign reg_addr = (state == S_REGS) ? index[RAW-1:0] : '0;
   assign mem_addr = (state == S_MEM)  ? index[MAW-1:0] : '0;

   // NOTE: every signal written here gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state;
      index_d  = index;
      valid_d  = out_valid;
      data_d   = out_data;
      addr_d   = out_addr;
      is_mem_d = out_is_mem;
      last_d   = out_last;

      if (accept) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_HALT;
            end
         end

         S_HALT: begin
            index_d = '0;
            state_d = S_REGS;
         end

         S_REGS: begin
            if (can_load) begin
               valid_d  = 1'b1;
               data_d   = reg_rdata;
               addr_d   = 16'(index);
               is_mem_d = 1'b0;
               last_d   = 1'b0;
               if (index == LAST_REG) begin
                  index_d = '0;
                  state_d = S_MEM;
               end else begin
                  index_d = index + IW'(1);
               end
            end
         end

         S_MEM: begin
            // Once the final word sits in the buffer, only its handshake remains.
            if (out_last) begin
               if (accept) begin
                  state_d = S_DONE;
               end
            end else if (can_load) begin
               valid_d  = 1'b1;
               data_d   = mem_rdata;
               addr_d   = 16'(index);
               is_mem_d = 1'b1;
               last_d   = (index == LAST_MEM);
               if (index != LAST_MEM) begin
                  index_d = index + IW'(1);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of the order these statements run in.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         index      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_addr   <= '0;
         out_is_mem <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         state      <= state_d;
         index      <= index_d;
         out_valid  <= valid_d;
         out_data   <= data_d;
         out_addr   <= addr_d;
         out_is_mem <= is_mem_d;
         out_last   <= last_d;
      end
   end

endmodule
